cache_assoc: RTL and testbench
==============================

Name: cache_assoc

Overview:
Parametrised successor to the direct-mapped write-through cache. It supports configurable data/address width, set count, block size and associativity (1 or 2 ways), with true-LRU replacement and a full-cache invalidate (flush) operation. It sits between the pipeline memory stage and the multi-cycle main memory. Policy is write-through, write-allocate: every miss fills the whole block, then the held request hits.

Parameters:
ADDR_W, 16, byte address width.
DATA_W, 16, word width; addr[0] is the byte select and is ignored.
INDEX_W, 6, set index bits; the cache has 2^INDEX_W sets.
WORD_W, 3, word-in-block bits; a block holds 2^WORD_W words.
WAYS, 2, associativity; only 1 or 2 are legal.
Derived: TAG_W = ADDR_W-INDEX_W-WORD_W-1 (6 by default). Field split: tag=addr[15:10], index=addr[9:4], word=addr[3:1].

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_addr  in  ADDR_W  request byte address.
req_wdata  in  DATA_W  store data.
req_ren  in  1  load request.
req_wen  in  1  store request; req_ren and req_wen are never both high.
stall  in  1  pipeline stall; requests are ignored while high.
flush  in  1  single-cycle pulse: invalidate all lines.
rdata  out  DATA_W  load data.
hit  out  1  request hit this cycle.
busy  out  1  the requester must hold its request.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data (equals req_wdata).
mem_ren  out  1  memory read issue.
mem_wen  out  1  memory write.
mem_rdata  in  DATA_W  memory return data.
mem_data_valid  in  1  mem_rdata is valid this cycle; returns arrive in issue order.

Behaviour:
- Storage:
  - Per way per set: valid bit, TAG_W tag, 2^WORD_W data words.
  - Per set: one LRU bit giving the way to evict. WAYS=1 means the LRU bit is unused.
- Reset (async):
  - All valid bits and LRU bits are 0; state is IDLE; fill and flush counters are 0.
  - busy=0, hit=0, mem_ren=0, mem_wen=0, rdata=0.
  - Data and tag arrays are not reset.
- Lookup is combinational, in IDLE only, with req=(req_ren|req_wen)&~stall:
  - hit = req & (some way valid with a matching tag).
  - On a hit, rdata = the addressed word of the hit way. Otherwise rdata = 0.
- Read hit: zero-cycle latency; busy=0. The set's LRU bit points to the other way at the clock edge.
- Write hit:
  - mem_wen=1, mem_addr=req_addr in the same cycle.
  - The hit word is written with req_wdata at the edge, and LRU is updated.
- Miss (req & ~hit in IDLE):
  - busy=1 combinationally in the same cycle; mem_wen=0.
  - The victim is latched: first invalid way (way0 priority), else the way named by the LRU bit.
  - Transition to FILL.
- FILL state:
  - busy=1.
  - Issue counter i runs from 0 to 2^WORD_W-1. Each cycle, mem_ren=1 and mem_addr = {tag,index,i,1'b0}.
  - Issue stops after the last word; mem_ren=0 thereafter.
  - Return counter r: each mem_data_valid writes mem_rdata to word r of the victim, then r increments.
  - When the final word returns:
    - the victim's tag is written and its valid bit set;
    - LRU points away from the victim;
    - the next state is IDLE.
  - The held request then hits on the following cycle; a write then performs its write-through.
  - stall does not pause FILL.
- FLUSH state:
  - Entered from IDLE on flush. flush wins over a simultaneous request (busy=1 that cycle, no hit).
  - Clears valid and LRU for one set per cycle, index 0 up to 2^INDEX_W-1 (64 cycles by default), with busy=1 throughout.
  - Then returns to IDLE.
- Flush during FILL: latched as pending; FLUSH starts directly after the fill completes.
- mem_data_valid outside FILL, or beyond 2^WORD_W returns, is ignored.
- Reset mid-FILL or mid-FLUSH:
  - Aborts immediately; the partially filled line stays invalid.
  - Late mem_data_valid after reset is ignored.
- Index wrap: fill addresses never carry into the index or tag fields.

Test Plan:
- Cold read: after reset, req_ren at 0x1234.
  - Required: busy=1 the same cycle; mem_addr 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles.
  - After 8 valids, the next cycle has hit=1 and rdata equal to the word returned for 0x1234.
- Write hit:
  - Required: store 0xBEEF to 0x1236 gives mem_wen=1, mem_addr=0x1236, busy=0.
  - A subsequent load of 0x1236 returns 0xBEEF with hit=1.
- Conflict/LRU:
  - Fill 0x1234 then 0x5634 (same index 0x23, tags 0x04 and 0x15); then read 0x1234 (hit); then read 0x9A34.
  - Required: way holding tag 0x15 is evicted; 0x1234 still hits and 0x5634 misses.
- WAYS=1 build: 0x1234 then 0x5634 then 0x1234 gives 3 misses.
- Flush:
  - Required: pulse flush with all lines valid; busy=1 for exactly 64 cycles, then every earlier-hitting address misses.
  - Flush issued mid-FILL: FLUSH follows immediately, and the filled line is also invalid afterward.
- Reset mid-FILL:
  - Assert rst_n=0 after 3 returned words, then release, then load the same address.
  - Required: full 8-word refill; stray mem_data_valid while IDLE has no effect.

Source files
------------

// File: rtl/cache_assoc.sv
// cache_assoc: parametrised 1/2-way set-associative write-through, write-allocate
// cache with true-LRU replacement and a full-cache flush. Lookup is combinational
// in IDLE; a miss fills the whole block from main memory, then the held request hits.
module cache_assoc #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int INDEX_W = 6,
  parameter int WORD_W  = 3,
  parameter int WAYS    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_ren,
  input  logic              req_wen,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] rdata,
  output logic              hit,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);
  localparam int TAG_W = ADDR_W - INDEX_W - WORD_W - 1;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_W;
  localparam logic [WORD_W-1:0]  LAST_WORD = WORD_W'(WORDS - 1);
  localparam logic [INDEX_W-1:0] LAST_SET  = INDEX_W'(SETS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t             r_state;
  logic [WAYS-1:0]    r_valid [SETS];
  logic [SETS-1:0]    r_lru;
  logic [TAG_W-1:0]   r_tag   [WAYS][SETS];
  logic [DATA_W-1:0]  r_data  [WAYS][SETS*WORDS];
  logic               r_victim;
  logic [TAG_W-1:0]   r_fill_tag;
  logic [INDEX_W-1:0] r_fill_index;
  logic [WORD_W-1:0]  r_issue;
  logic               r_issue_done;
  logic [WORD_W-1:0]  r_ret;
  logic               r_flush_pend;
  logic [INDEX_W-1:0] r_flush_idx;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [WORD_W-1:0]  w_word;
  logic               w_unused_byte_sel;
  logic               w_idle;
  logic               w_req;
  logic               w_flush_go;
  logic               w_lookup;
  logic [WAYS-1:0]    w_match;
  logic               w_hit_way;
  logic               w_victim_way;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill_en;
  logic               w_fill_last;

  assign w_tag             = req_addr[ADDR_W-1 -: TAG_W];
  assign w_index           = req_addr[WORD_W+1 +: INDEX_W];
  assign w_word            = req_addr[1 +: WORD_W];
  assign w_unused_byte_sel = req_addr[0];
  assign w_idle            = (r_state == S_IDLE);
  assign w_req             = (req_ren | req_wen) & ~stall;
  // flush takes priority over a request arriving in the same cycle
  assign w_flush_go        = w_idle & flush;
  assign w_lookup          = w_idle & ~flush & w_req;

  generate
    for (genvar g = 0; g < WAYS; g++) begin : g_match
      assign w_match[g] = r_valid[w_index][g] & (r_tag[g][w_index] == w_tag);
    end
    if (WAYS == 1) begin : g_one_way
      assign w_hit_way    = 1'b0;
      assign w_victim_way = 1'b0;
    end else begin : g_two_way
      assign w_hit_way    = ~w_match[0];
      // first invalid way (way0 first), otherwise the way the LRU bit names
      assign w_victim_way = ~r_valid[w_index][0] ? 1'b0 :
                            (~r_valid[w_index][1] ? 1'b1 : r_lru[w_index]);
    end
  endgenerate

  assign w_hit       = w_lookup & (|w_match);
  assign w_miss      = w_lookup & ~(|w_match);
  // returns are only accepted while filling; extra or stray returns are dropped
  assign w_fill_en   = (r_state == S_FILL) & mem_data_valid;
  assign w_fill_last = w_fill_en & (r_ret == LAST_WORD);

  assign hit       = w_hit;
  assign rdata     = w_hit ? r_data[w_hit_way][{w_index, w_word}] : {DATA_W{1'b0}};
  assign busy      = ~w_idle | w_flush_go | w_miss;
  assign mem_ren   = (r_state == S_FILL) & ~r_issue_done;
  assign mem_wen   = w_hit & req_wen;
  // fill addresses keep the latched tag/index so the word counter never carries upward
  assign mem_addr  = (r_state == S_FILL) ? {r_fill_tag, r_fill_index, r_issue, 1'b0} : req_addr;
  assign mem_wdata = req_wdata;

  // Control state, valid bits, LRU bits and fill/flush counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      for (int s = 0; s < SETS; s++) r_valid[s] <= {WAYS{1'b0}};
      r_lru        <= {SETS{1'b0}};
      r_victim     <= 1'b0;
      r_fill_tag   <= {TAG_W{1'b0}};
      r_fill_index <= {INDEX_W{1'b0}};
      r_issue      <= {WORD_W{1'b0}};
      r_issue_done <= 1'b0;
      r_ret        <= {WORD_W{1'b0}};
      r_flush_pend <= 1'b0;
      r_flush_idx  <= {INDEX_W{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_flush_go) begin
            // set 0 is cleared in the pulse cycle so the whole flush is SETS cycles long
            r_valid[0]  <= {WAYS{1'b0}};
            r_lru[0]    <= 1'b0;
            r_flush_idx <= INDEX_W'(1);
            r_state     <= S_FLUSH;
          end else if (w_hit) begin
            r_lru[w_index] <= ~w_hit_way;
          end else if (w_miss) begin
            // the victim is invalidated up front so a partial fill can never hit
            r_valid[w_index][w_victim_way] <= 1'b0;
            r_victim     <= w_victim_way;
            r_fill_tag   <= w_tag;
            r_fill_index <= w_index;
            r_issue      <= {WORD_W{1'b0}};
            r_issue_done <= 1'b0;
            r_ret        <= {WORD_W{1'b0}};
            r_state      <= S_FILL;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (!r_issue_done) begin
            r_issue <= r_issue + WORD_W'(1);
            if (r_issue == LAST_WORD) r_issue_done <= 1'b1;
          end
          if (w_fill_en) r_ret <= r_ret + WORD_W'(1);
          if (w_fill_last) begin
            r_valid[r_fill_index][r_victim] <= 1'b1;
            r_lru[r_fill_index] <= ~r_victim;
            if (r_flush_pend | flush) begin
              r_flush_pend <= 1'b0;
              r_flush_idx  <= {INDEX_W{1'b0}};
              r_state      <= S_FLUSH;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FLUSH: begin
          r_valid[r_flush_idx] <= {WAYS{1'b0}};
          r_lru[r_flush_idx]   <= 1'b0;
          r_flush_idx          <= r_flush_idx + INDEX_W'(1);
          if (r_flush_idx == LAST_SET) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data and tag arrays: write-hit stores and fill returns (not reset).
  always_ff @(posedge clk) begin
    if (w_hit && req_wen) begin
      r_data[w_hit_way][{w_index, w_word}] <= req_wdata;
    end else if (w_fill_en) begin
      r_data[r_victim][{r_fill_index, r_ret}] <= mem_rdata;
      if (r_ret == LAST_WORD) r_tag[r_victim][r_fill_index] <= r_fill_tag;
    end else begin
      r_tag[0][0] <= r_tag[0][0];
    end
  end
endmodule

// File: tb/tb_cache_assoc.sv
// Self-checking bench for cache_assoc: a 2-way instance (index 0) and a 1-way
// instance (index 1), a randomly-timed in-order memory, and an LRU-list model.
module tb_cache_assoc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0][15:0] req_addr, req_wdata, mem_rdata, rdata, mem_addr, mem_wdata;
  logic [1:0] req_ren, req_wen, stall, flush, mem_data_valid;
  logic [1:0] hit, busy, mem_ren, mem_wen, stray;
  int n_checks = 0;
  int n_fail = 0;
  int n_miss [2];

  always #5 clk = ~clk;

  cache_assoc #(.WAYS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_ren(req_ren[0]), .req_wen(req_wen[0]), .stall(stall[0]), .flush(flush[0]),
    .rdata(rdata[0]), .hit(hit[0]), .busy(busy[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_ren(mem_ren[0]), .mem_wen(mem_wen[0]),
    .mem_rdata(mem_rdata[0]), .mem_data_valid(mem_data_valid[0]));

  cache_assoc #(.WAYS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_ren(req_ren[1]), .req_wen(req_wen[1]), .stall(stall[1]), .flush(flush[1]),
    .rdata(rdata[1]), .hit(hit[1]), .busy(busy[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_ren(mem_ren[1]), .mem_wen(mem_wen[1]),
    .mem_rdata(mem_rdata[1]), .mem_data_valid(mem_data_valid[1]));

  // initial memory image: distinct value per word address
  function automatic logic [15:0] base_word(input logic [14:0] w);
    return 16'({1'b0, w} * 16'h9E37 + 16'h1234);
  endfunction

  // main memory: write-through updates plus in-order returns with random gaps
  logic [15:0] mem_arr [32768];
  bit   [32767:0] mem_wrote;
  logic [14:0] pend_q [2][$];

  function automatic logic [15:0] mem_read(input logic [14:0] w);
    return mem_wrote[w] ? mem_arr[w] : base_word(w);
  endfunction

  // memory responder for both instances
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q[0].delete();
      pend_q[1].delete();
      mem_data_valid <= 2'b00;
      mem_rdata      <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_wen[k]) begin
          mem_arr[mem_addr[k][15:1]]   <= mem_wdata[k];
          mem_wrote[mem_addr[k][15:1]] <= 1'b1;
        end
        if (pend_q[k].size() > 0 && $urandom_range(0, 3) != 0) begin
          mem_data_valid[k] <= 1'b1;
          mem_rdata[k]      <= mem_read(pend_q[k].pop_front());
        end else if (stray[k]) begin
          mem_data_valid[k] <= 1'b1;
          mem_rdata[k]      <= 16'hDEAD;
        end else begin
          mem_data_valid[k] <= 1'b0;
        end
        if (mem_ren[k]) pend_q[k].push_back(mem_addr[k][15:1]);
      end
    end
  end

  // reference: per set, resident tags ordered most- to least-recently used
  logic [5:0]  mq [2][64][$];
  logic [15:0] exp_wr [int];

  function automatic bit m_hit(input int k, input logic [15:0] a);
    int s = int'(a[9:4]);
    for (int i = 0; i < mq[k][s].size(); i++)
      if (mq[k][s][i] == a[15:10]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_touch(input int k, input logic [15:0] a);
    int s = int'(a[9:4]);
    for (int i = 0; i < mq[k][s].size(); i++) begin
      if (mq[k][s][i] == a[15:10]) begin
        mq[k][s].delete(i);
        break;
      end
    end
    mq[k][s].push_front(a[15:10]);
    if (mq[k][s].size() > ((k == 0) ? 2 : 1)) void'(mq[k][s].pop_back());
  endfunction

  function automatic void m_clear(input int k);
    for (int s = 0; s < 64; s++) mq[k][s].delete();
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    int w = int'(a[15:1]);
    return exp_wr.exists(w) ? exp_wr[w] : base_word(a[15:1]);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one load/store on instance k, held until it hits; checks fill address sequence
  task automatic access(input int k, input bit wr, input logic [15:0] a,
                        input logic [15:0] wd, input string tag);
    bit exp_hit;
    int cyc, issued;
    exp_hit = m_hit(k, a);
    @(negedge clk);
    req_addr[k] = a; req_wdata[k] = wd; req_ren[k] = !wr; req_wen[k] = wr;
    #1;
    check({tag, " busy"}, 16'(busy[k]), 16'(!exp_hit));
    if (busy[k]) n_miss[k]++;
    cyc = 0; issued = 0;
    while (!hit[k] && cyc < 300) begin
      if (mem_ren[k]) begin
        check({tag, " fill addr"}, mem_addr[k], {a[15:4], 3'(issued), 1'b0});
        check({tag, " fill cycle"}, 16'(cyc), 16'(issued + 1));
        issued++;
      end
      @(negedge clk); #1; cyc++;
    end
    check({tag, " hit"}, 16'(hit[k]), 16'd1);
    check({tag, " issues"}, 16'(issued), exp_hit ? 16'd0 : 16'd8);
    if (wr) begin
      check({tag, " mem_wen"}, 16'(mem_wen[k]), 16'd1);
      check({tag, " mem_addr"}, mem_addr[k], a);
      check({tag, " mem_wdata"}, mem_wdata[k], wd);
      exp_wr[int'(a[15:1])] = wd;
    end else begin
      check({tag, " rdata"}, rdata[k], exp_word(a));
    end
    m_touch(k, a);
    @(negedge clk);
    req_ren[k] = 1'b0; req_wen[k] = 1'b0;
  endtask

  initial begin
    int cyc, issued, rets, m0;
    bit fl_done;
    logic [15:0] a;
    req_addr = '0; req_wdata = '0; req_ren = '0; req_wen = '0;
    stall = '0; flush = '0; stray = '0;
    n_miss[0] = 0; n_miss[1] = 0;

    // reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst busy", 16'(busy[0]), 16'd0);
    check("rst hit", 16'(hit[0]), 16'd0);
    check("rst mem_ren", 16'(mem_ren[0]), 16'd0);
    check("rst mem_wen", 16'(mem_wen[0]), 16'd0);
    check("rst rdata", rdata[0], 16'h0000);
    rst_n = 1'b1;

    // cold read, write hit, then read back
    access(0, 1'b0, 16'h1234, 16'h0000, "cold");
    access(0, 1'b1, 16'h1236, 16'hBEEF, "whit");
    access(0, 1'b0, 16'h1236, 16'h0000, "rdback");
    check("rdback value", exp_word(16'h1236), 16'hBEEF);

    // conflict in set 0x23: tag 0x15 becomes LRU and is evicted
    m0 = n_miss[0];
    access(0, 1'b0, 16'h5634, 16'h0000, "lru a");
    access(0, 1'b0, 16'h1234, 16'h0000, "lru b");
    access(0, 1'b0, 16'h9A34, 16'h0000, "lru c");
    access(0, 1'b0, 16'h1234, 16'h0000, "lru d");
    access(0, 1'b0, 16'h5634, 16'h0000, "lru e");
    check("lru misses", 16'(n_miss[0] - m0), 16'd3);

    // single-way instance: every conflicting access misses
    m0 = n_miss[1];
    access(1, 1'b0, 16'h1234, 16'h0000, "w1 a");
    access(1, 1'b0, 16'h5634, 16'h0000, "w1 b");
    access(1, 1'b0, 16'h1234, 16'h0000, "w1 c");
    check("w1 misses", 16'(n_miss[1] - m0), 16'd3);

    // stall masks a request to a resident line
    @(negedge clk);
    stall[0] = 1'b1; req_ren[0] = 1'b1; req_addr[0] = 16'h1234;
    #1;
    check("stall hit", 16'(hit[0]), 16'd0);
    check("stall busy", 16'(busy[0]), 16'd0);
    check("stall rdata", rdata[0], 16'h0000);

    // flush pulse with a simultaneous request: 64 busy cycles, no hit
    @(negedge clk);
    stall[0] = 1'b0; flush[0] = 1'b1;
    #1;
    check("flush req hit", 16'(hit[0]), 16'd0);
    cyc = 0;
    while (busy[0] && cyc < 300) begin
      cyc++;
      @(negedge clk); flush[0] = 1'b0; req_ren[0] = 1'b0; #1;
    end
    check("flush busy cycles", 16'(cyc), 16'd64);
    m_clear(0);
    access(0, 1'b0, 16'h1234, 16'h0000, "post flush a");
    access(0, 1'b0, 16'h5634, 16'h0000, "post flush b");

    // flush during a fill: flush follows, then the held load refills
    a = 16'h2468;
    @(negedge clk);
    req_addr[0] = a; req_ren[0] = 1'b1;
    #1;
    cyc = 0; issued = 0; fl_done = 1'b0;
    while (!hit[0] && cyc < 600) begin
      if (mem_ren[0]) issued++;
      @(negedge clk);
      if (flush[0]) flush[0] = 1'b0;
      else if (issued == 3 && !fl_done) begin flush[0] = 1'b1; fl_done = 1'b1; end
      #1; cyc++;
    end
    check("midfill hit", 16'(hit[0]), 16'd1);
    check("midfill issues", 16'(issued), 16'd16);
    check("midfill long", 16'(cyc >= 81), 16'd1);
    check("midfill rdata", rdata[0], exp_word(a));
    @(negedge clk); req_ren[0] = 1'b0;
    m_clear(0);
    m_touch(0, a);
    access(0, 1'b0, 16'h1234, 16'h0000, "midfill other");

    // reset after three returned words, stray return while idle, then refill
    a = 16'h4C5A;
    @(negedge clk);
    req_addr[0] = a; req_ren[0] = 1'b1;
    rets = 0; cyc = 0;
    while (rets < 3 && cyc < 300) begin
      @(negedge clk); #1; cyc++;
      if (mem_data_valid[0]) rets++;
    end
    check("rst mid returns", 16'(rets), 16'd3);
    rst_n = 1'b0; req_ren[0] = 1'b0;
    @(negedge clk); #1;
    check("rst mid busy", 16'(busy[0]), 16'd0);
    rst_n = 1'b1;
    m_clear(0); m_clear(1);
    @(negedge clk); stray[0] = 1'b1;
    @(negedge clk); stray[0] = 1'b0; #1;
    check("stray busy", 16'(busy[0]), 16'd0);
    check("stray hit", 16'(hit[0]), 16'd0);
    access(0, 1'b0, a, 16'h0000, "refill");

    // random loads/stores over a few conflicting sets
    for (int n = 0; n < 200; n++) begin
      logic [5:0] tg, ix;
      case ($urandom_range(0, 3))
        0: tg = 6'h04;
        1: tg = 6'h15;
        2: tg = 6'h26;
        default: tg = 6'h3F;
      endcase
      case ($urandom_range(0, 2))
        0: ix = 6'h23;
        1: ix = 6'h00;
        default: ix = 6'h3F;
      endcase
      a = {tg, ix, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      access(0, ($urandom_range(0, 3) == 0), a, 16'($urandom), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
